mul_wb_queue: RTL and testbench
===============================

# mul_wb_queue

Completion buffer directly downstream of the fixed-latency multiply/FP pipeline. The multiplier cannot stall, so this block captures every completing result, holds it in a small FIFO, and presents it to the shared writeback/PRF port with a valid/ready handshake. It also gates the scheduler's issue of new multiply ops with a credit check, so a completing result always finds a free slot.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- LAT, 4: multiplier pipeline register depth; matches `MUL_LAT`+1 cycles from go to complete. Used only for assertion checks.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- issue_go  in  1  scheduler issues one op to the multiplier this cycle.
- can_issue  out  1  multiplier issue permitted this cycle.
- mul_complete  in  1  multiplier result valid this cycle.
- mul_y  in  `M_WIDTH`  result data.
- mul_rob_ptr  in  `LG_ROB_ENTRIES`  ROB tag.
- mul_prf_val  in  1  result writes a PRF entry.
- mul_prf_ptr  in  `LG_PRF_ENTRIES`  destination PRF entry.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  writeback port accepts the head.
- wb_y, wb_rob_ptr, wb_prf_val, wb_prf_ptr  out  as above  head entry fields.
- occupancy  out  $clog2(DEPTH+1)  entries held.
- overflow  out  1  sticky error: push arrived while full.

## Operation
- Storage: DEPTH entries {y, rob_ptr, prf_val, prf_ptr}. The read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register is $clog2(DEPTH+1) bits.
- Push: mul_complete=1 writes an entry at the write pointer.
- Pop: wb_valid & wb_ready advances the read pointer.
- Simultaneous push and pop: the count is unchanged. If the FIFO is full, the push is accepted because the pop frees the slot in the same cycle.
- In-flight counter `inflight` ($clog2(DEPTH+1) bits):
  - +1 on issue_go.
  - −1 on mul_complete.
  - Unchanged when both occur in the same cycle.
- can_issue = (count + inflight) < DEPTH. It is computed from registers only, with no combinational path from wb_ready.
- issue_go while can_issue=0 is illegal and is caught by an assertion. The block takes no other action on it.
- Push while full with no pop:
  - The entry is dropped.
  - overflow is set and stays set until reset.
  - Count and pointers are unchanged.
- wb_* data outputs always show the head entry. After reset they are 0.
- Reset mid-operation clears count, pointers, inflight, overflow and storage. Results still in flight in the multiplier are the caller's responsibility: reset covers both blocks.

## Timing
- Reset values: wb_valid=0, wb_* data=0, can_issue=1, occupancy=0, overflow=0.
- Without bypass:
  - mul_complete in cycle N gives wb_valid=1 in cycle N+1 with that entry's data.
  - Earliest pop is in N+1.
- Back-to-back completions with wb_ready held at 1 sustain 1 result/cycle at steady state.
- Credit release:
  - can_issue rises the cycle after the pop that frees the slot.
  - inflight+count never exceeds DEPTH, so overflow is unreachable under legal stimulus.
- wb_valid depends only on registered count. It has no combinational dependence on wb_ready.

## Configuration
- MUL_WB_BYPASS_EN defined:
  - When count=0 and mul_complete=1, the wb_* outputs show mul_* in the same cycle and wb_valid=1 combinationally.
  - If wb_ready=1 in that cycle, the entry is not written (zero latency).
  - Otherwise the entry is written as normal.
- MUL_WB_BYPASS_EN undefined: no bypass; minimum latency is one cycle, as above.
- can_issue rules are identical in both builds.

## Structure
- Package mul_wb_pkg holds:
  - typedef mul_wb_entry_t, a packed struct {y, rob_ptr, prf_val, prf_ptr} whose widths come from the machine.vh macros.
  - localparam for the default DEPTH.
- Sub-module wb_fifo: a generic synchronous FIFO parameterised by entry type and DEPTH. It provides push, pop, full, empty and count.
- The top level holds the credit counter, overflow flag, bypass mux and assertions.

## Test plan
- Reset, then idle → wb_valid=0, can_issue=1, occupancy=0, overflow=0.
- Single op: issue_go at cycle 0, mul_complete at cycle 5 with y=0x1234, rob=3, prf=17, wb_ready=1 → wb_valid at cycle 6 with those values; popped in cycle 6, occupancy back to 0.
  - With MUL_WB_BYPASS_EN, the result appears in cycle 5 and occupancy stays 0.
- Fill, DEPTH=4, wb_ready=0:
  - 4 issues → can_issue=0 after the 4th.
  - 4 completions → occupancy=4.
  - wb_ready=1 for one cycle → pops rob 0, and can_issue=1 the next cycle.
- Full with simultaneous push and pop, with overflow forced by stimulus:
  - At occupancy=4, mul_complete & wb_ready → occupancy stays 4 and FIFO order is preserved.
  - mul_complete with wb_ready=0 → overflow=1, occupancy 4, entry dropped.
- Wrap-around: stream 10 results (rob 0..9) with wb_ready toggling 1,0,1,0 → output order is rob 0..9 with no loss or duplication.
- Reset mid-stream at occupancy=3, inflight=1 → next cycle all counters are 0, wb_valid=0, can_issue=1.

Source files
------------

// File: rtl/mul_wb_queue_pkg.sv
// mul_wb_pkg: shared types for the multiply completion/writeback queue.
// Widths come from the machine-level macros M_WIDTH, LG_ROB_ENTRIES and
// LG_PRF_ENTRIES. Fallback values are used when machine.vh has not defined them.
// Contents:
//   MUL_WB_DEPTH   - default number of completion-buffer entries
//   Y_W/ROB_W/PRF_W - field widths
//   mul_wb_entry_t - one buffered multiply result
`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 7
`endif

package mul_wb_pkg;
    localparam int MUL_WB_DEPTH = 4;
    localparam int Y_W          = `M_WIDTH;
    localparam int ROB_W        = `LG_ROB_ENTRIES;
    localparam int PRF_W        = `LG_PRF_ENTRIES;

    typedef struct packed {
        logic [Y_W-1:0]   y;
        logic [ROB_W-1:0] rob_ptr;
        logic             prf_val;
        logic [PRF_W-1:0] prf_ptr;
    } mul_wb_entry_t;
endpackage

// File: rtl/mul_wb_queue_if.sv
// mul_wb_queue_if: the bus between the scheduler, the multiplier and the
// writeback port on one side, and the completion queue on the other.
//   issue_go / can_issue       - scheduler issue and credit grant
//   mul_complete, mul_*        - multiplier result, valid for one cycle
//   wb_valid / wb_ready, wb_*  - head-of-queue handshake to the PRF writeback
// Modports:
//   slave  - the queue
//   master - the surrounding pipeline (or a testbench)
interface mul_wb_queue_if;
    import mul_wb_pkg::*;

    logic             issue_go;
    logic             can_issue;
    logic             mul_complete;
    logic [Y_W-1:0]   mul_y;
    logic [ROB_W-1:0] mul_rob_ptr;
    logic             mul_prf_val;
    logic [PRF_W-1:0] mul_prf_ptr;
    logic             wb_valid;
    logic             wb_ready;
    logic [Y_W-1:0]   wb_y;
    logic [ROB_W-1:0] wb_rob_ptr;
    logic             wb_prf_val;
    logic [PRF_W-1:0] wb_prf_ptr;

    modport slave (
        input  issue_go, mul_complete, mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr, wb_ready,
        output can_issue, wb_valid, wb_y, wb_rob_ptr, wb_prf_val, wb_prf_ptr
    );

    modport master (
        output issue_go, mul_complete, mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr, wb_ready,
        input  can_issue, wb_valid, wb_y, wb_rob_ptr, wb_prf_val, wb_prf_ptr
    );
endinterface

// File: rtl/mul_wb_queue_wb_fifo.sv
// wb_fifo: generic synchronous FIFO.
// Parameters:
//   T     - entry type
//   DEPTH - number of entries, power of two, >= 2
// Ports:
//   clk, reset (sync, active-high)
//   push/din      - write request
//   pop           - read request
//   dout          - current head entry
//   full, empty, count
// Behaviour:
//   - A pop on an empty FIFO is ignored.
//   - A push on a full FIFO is accepted only if a pop frees the slot in the
//     same cycle; otherwise it is dropped.
//   - Reset clears the storage, so dout reads zero after reset.
module wb_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mul_wb_queue.sv
// mul_wb_queue: completion buffer behind the non-stallable multiply pipeline.
// Every completing result is captured in a small FIFO. The FIFO head is
// offered to the shared PRF writeback port. Issue of new multiply ops is
// gated by a credit check, so a completion always finds a free slot.
// Parameters:
//   DEPTH - FIFO entries, power of two, >= 2
//   LAT   - multiplier register depth; only used by the checks
// Ports:
//   clk, reset (sync, active-high)
//   bus       - mul_wb_queue_if.slave (issue, completion, writeback)
//   occupancy - entries currently held
//   overflow  - sticky; a result arrived while full with no pop
// Build option:
//   MUL_WB_BYPASS_EN - when the queue is empty, a completing result is
//   presented on wb_* in the same cycle. It skips the FIFO if accepted.
module mul_wb_queue
    import mul_wb_pkg::*;
#(
    parameter int  DEPTH = MUL_WB_DEPTH,
    parameter int  LAT   = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_wb_queue_if.slave        bus,
    output logic [CW-1:0]        occupancy,
    output logic                 overflow
);
    mul_wb_entry_t din, head, wb_sel;
    logic [CW-1:0] count, inflight;
    logic          full, empty, bypass, push, pop;

    assign din = '{y:       bus.mul_y,
                   rob_ptr: bus.mul_rob_ptr,
                   prf_val: bus.mul_prf_val,
                   prf_ptr: bus.mul_prf_ptr};

`ifdef MUL_WB_BYPASS_EN
    assign bypass = empty & bus.mul_complete;
`else
    assign bypass = 1'b0;
`endif

    // Without bypass, wb_valid comes only from registered FIFO state.
    assign bus.wb_valid   = ~empty | bypass;
    assign pop            = ~empty & bus.wb_ready;
    // A bypassed result that is accepted immediately never enters the FIFO.
    assign push           = bus.mul_complete & ~(bypass & bus.wb_ready);

    assign wb_sel         = bypass ? din : head;
    assign bus.wb_y       = wb_sel.y;
    assign bus.wb_rob_ptr = wb_sel.rob_ptr;
    assign bus.wb_prf_val = wb_sel.prf_val;
    assign bus.wb_prf_ptr = wb_sel.prf_ptr;
    assign occupancy      = count;

    // Credits come from registers only: slots held plus results still in the
    // pipe. The sum is one bit wider, so it cannot wrap.
    assign bus.can_issue  = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);

    wb_fifo #(.T(mul_wb_entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            // A completion with nothing in flight comes from illegal stimulus.
            // In that case inflight holds at zero instead of wrapping.
            case ({bus.issue_go, bus.mul_complete})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= (inflight != '0) ? inflight - CW'(1) : inflight;
                default: inflight <= inflight;
            endcase
            if (bus.mul_complete & full & ~pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.issue_go && !bus.can_issue));
            assert (int'(inflight) <= LAT + 1);
        end
    end
endmodule

// File: tb/tb_mul_wb_queue.sv
module tb_mul_wb_queue;
    import mul_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef MUL_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] occupancy;
    logic          overflow;

    mul_wb_queue_if bus();

    mul_wb_queue #(.DEPTH(DEPTH), .LAT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic complete(input logic [63:0] y, input int rob, input int prf);
        bus.mul_complete = 1'b1;
        bus.mul_y        = Y_W'(y);
        bus.mul_rob_ptr  = ROB_W'(rob);
        bus.mul_prf_val  = 1'b1;
        bus.mul_prf_ptr  = PRF_W'(prf);
    endtask

    initial begin
        int  m_cnt, pushed, popped;
        bit  rdy, psh, pop_m, byp_take;

        reset = 1'b1;
        bus.issue_go = 1'b0; bus.mul_complete = 1'b0; bus.mul_y = '0;
        bus.mul_rob_ptr = '0; bus.mul_prf_val = 1'b0; bus.mul_prf_ptr = '0;
        bus.wb_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_can_issue", 64'(bus.can_issue), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_wb_y", 64'(bus.wb_y), 64'd0);
        chk("rst_wb_rob", 64'(bus.wb_rob_ptr), 64'd0);

        // single op: issue in cycle 0, complete in cycle 5
        bus.issue_go = 1'b1;
        tick();
        bus.issue_go = 1'b0;
        #1;
        chk("single_can_issue", 64'(bus.can_issue), 64'd1);
        repeat (4) tick();
        complete(64'h1234, 3, 17);
        bus.wb_ready = 1'b1;
        #1;
        chk("single_c5_valid", 64'(bus.wb_valid), BYP ? 64'd1 : 64'd0);
        if (BYP) chk("single_c5_rob", 64'(bus.wb_rob_ptr), 64'd3);
        tick();
        bus.mul_complete = 1'b0;
        #1;
        if (!BYP) begin
            chk("single_c6_valid", 64'(bus.wb_valid), 64'd1);
            chk("single_c6_y", 64'(bus.wb_y), 64'h1234);
            chk("single_c6_rob", 64'(bus.wb_rob_ptr), 64'd3);
            chk("single_c6_prf_val", 64'(bus.wb_prf_val), 64'd1);
            chk("single_c6_prf", 64'(bus.wb_prf_ptr), 64'd17);
            chk("single_c6_occ", 64'(occupancy), 64'd1);
        end else begin
            chk("single_byp_occ", 64'(occupancy), 64'd0);
        end
        tick();
        chk("single_drained_occ", 64'(occupancy), 64'd0);
        chk("single_drained_valid", 64'(bus.wb_valid), 64'd0);

        // fill with wb_ready low
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.issue_go = 1'b1;
            tick();
        end
        bus.issue_go = 1'b0;
        #1;
        chk("fill_can_issue_0", 64'(bus.can_issue), 64'd0);
        for (int i = 0; i < 4; i++) begin
            complete(64'h100 + 64'(i), i, i + 8);
            tick();
        end
        bus.mul_complete = 1'b0;
        #1;
        chk("fill_occ4", 64'(occupancy), 64'd4);
        chk("fill_can_issue_full", 64'(bus.can_issue), 64'd0);
        chk("fill_valid", 64'(bus.wb_valid), 64'd1);
        chk("fill_head_rob", 64'(bus.wb_rob_ptr), 64'd0);
        chk("fill_head_y", 64'(bus.wb_y), 64'h100);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        #1;
        chk("fill_pop_occ", 64'(occupancy), 64'd3);
        chk("fill_credit_back", 64'(bus.can_issue), 64'd1);
        chk("fill_next_head", 64'(bus.wb_rob_ptr), 64'd1);

        // back to full, then push+pop while full, then forced overflow
        bus.issue_go = 1'b1;
        tick();
        bus.issue_go = 1'b0;
        complete(64'h104, 4, 12);
        tick();
        bus.mul_complete = 1'b0;
        #1;
        chk("full_occ4", 64'(occupancy), 64'd4);
        chk("full_can_issue", 64'(bus.can_issue), 64'd0);
        complete(64'h105, 5, 13);
        bus.wb_ready = 1'b1;
        #1;
        chk("pp_head_before", 64'(bus.wb_rob_ptr), 64'd1);
        tick();
        complete(64'h106, 6, 14);
        bus.wb_ready = 1'b0;
        #1;
        chk("pp_occ4", 64'(occupancy), 64'd4);
        chk("pp_head_after", 64'(bus.wb_rob_ptr), 64'd2);
        chk("pp_no_overflow", 64'(overflow), 64'd0);
        tick();
        bus.mul_complete = 1'b0;
        #1;
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_occ4", 64'(occupancy), 64'd4);
        chk("ovf_head", 64'(bus.wb_rob_ptr), 64'd2);
        bus.wb_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            #1;
            chk("drain_order", 64'(bus.wb_rob_ptr), 64'(k));
            chk("drain_y", 64'(bus.wb_y), 64'h100 + 64'(k));
            tick();
        end
        bus.wb_ready = 1'b0;
        #1;
        chk("drain_empty_valid", 64'(bus.wb_valid), 64'd0);
        chk("drain_occ0", 64'(occupancy), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // wrap-around stream, rob 0..9, wb_ready toggling 1,0,1,0
        m_cnt = 0; pushed = 0; popped = 0;
        for (int c = 0; c < 60 && popped < 10; c++) begin
            rdy = (c % 2 == 0);
            psh = (pushed < 10) && (m_cnt < DEPTH || (rdy && m_cnt > 0));
            bus.wb_ready = rdy;
            if (psh) complete(64'h200 + 64'(pushed), pushed, pushed);
            else bus.mul_complete = 1'b0;
            #1;
            chk("wrap_valid", 64'(bus.wb_valid), 64'(m_cnt > 0 || (BYP && psh)));
            byp_take = BYP && psh && rdy && (m_cnt == 0);
            pop_m    = rdy && (m_cnt > 0 || byp_take);
            if (pop_m) begin
                chk("wrap_order", 64'(bus.wb_rob_ptr), 64'(popped));
                popped++;
            end
            m_cnt += ((psh && !byp_take) ? 1 : 0) - ((pop_m && !byp_take) ? 1 : 0);
            if (psh) pushed++;
            tick();
            chk("wrap_occ", 64'(occupancy), 64'(m_cnt));
        end
        bus.mul_complete = 1'b0;
        bus.wb_ready = 1'b0;
        chk("wrap_all_popped", 64'(popped), 64'd10);
        chk("wrap_final_occ", 64'(occupancy), 64'd0);

        // reset mid-stream: occupancy 3, inflight 1
        for (int i = 0; i < 4; i++) begin
            bus.issue_go = 1'b1;
            tick();
        end
        bus.issue_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            complete(64'h300 + 64'(i), i, i);
            tick();
        end
        bus.mul_complete = 1'b0;
        #1;
        chk("mid_occ3", 64'(occupancy), 64'd3);
        chk("mid_can_issue", 64'(bus.can_issue), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mrst_occ", 64'(occupancy), 64'd0);
        chk("mrst_valid", 64'(bus.wb_valid), 64'd0);
        chk("mrst_can_issue", 64'(bus.can_issue), 64'd1);
        chk("mrst_overflow", 64'(overflow), 64'd0);
        chk("mrst_wb_y", 64'(bus.wb_y), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
